// File: rtl/cht_pkg.sv
// Shared types and constants for the cht shift-chain family.
// Serializer state encoding and serial direction codes.
package cht_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cht_ser_state_e;

    localparam logic CHT_DIR_LSB = 1'b0;
    localparam logic CHT_DIR_MSB = 1'b1;

endpackage

// File: rtl/cht_chain_serializer.sv
// Parallel-to-serial transmitter feeding a cht receiving chain.
// One bit per accepted transfer; zero-bubble reload on the final bit.
module cht_chain_serializer
    import cht_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    cht_ser_state_e   state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;

    logic in_shift;
    logic xfer;
    logic load_fire;

    assign in_shift   = (state_q == SHIFT);
    assign xfer       = in_shift && ser_ready;
    assign ser_valid  = in_shift;
    assign busy       = in_shift;
    assign ser_last   = in_shift && (cnt_q == '0);
    assign load_ready = !in_shift || (ser_last && ser_ready);
    assign load_fire  = load_valid && load_ready;

    always_comb begin
        ser_data = 1'b0;
        if (in_shift) begin
            ser_data = (dir_q == CHT_DIR_MSB) ? sreg_q[WIDTH-1] : sreg_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (clr) begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
            dir_d   = CHT_DIR_LSB;
        end else begin
            if (xfer) begin
                if (dir_q == CHT_DIR_MSB) begin
                    sreg_d = sreg_q << 1;
                end else begin
                    sreg_d = sreg_q >> 1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            // a load on the final transfer overrides the return to IDLE
            if (load_fire) begin
                sreg_d  = load_data;
                dir_d   = load_dir;
                cnt_d   = CNT_LAST;
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= CHT_DIR_LSB;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_cht_chain_serializer.sv
// Self-checking bench for cht_chain_serializer (WIDTH=16).
// Directed vector table, corner sequences and a randomized queue model.
module tb_cht_chain_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         load_dir = 1'b0;
    logic         ser_valid;
    logic         ser_ready = 1'b0;
    logic         ser_data;
    logic         ser_last;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cht_chain_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         dir;
        logic [W-1:0] seq;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".load_ready"}, 64'(load_ready), 64'd1);
        chk({nm, ".ser_valid"}, 64'(ser_valid), 64'd0);
        chk({nm, ".ser_data"}, 64'(ser_data), 64'd0);
        chk({nm, ".ser_last"}, 64'(ser_last), 64'd0);
        chk({nm, ".busy"}, 64'(busy), 64'd0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a word in an idle cycle; returns just after the accepting edge.
    task automatic load_word(input logic [W-1:0] d, input logic dir);
        load_valid = 1'b1;
        load_data  = d;
        load_dir   = dir;
        @(negedge clk);
        chk("load.ready", 64'(load_ready), 64'd1);
        next_cyc();
        load_valid = 1'b0;
        load_data  = $urandom;
        load_dir   = $urandom;
    endtask

    function automatic logic exp_bit(input logic [W-1:0] d, input logic dir,
                                     input int i);
        return dir ? d[W-1-i] : d[i];
    endfunction

    vec_t vecs[6];

    // reference model state for the random phase
    bit   mq[$];
    logic exp_rdy;

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
        vecs[1] = '{16'hA5C3, 1'b1, 16'hC3A5};
        vecs[2] = '{16'h0001, 1'b0, 16'h0001};
        vecs[3] = '{16'h8000, 1'b1, 16'h0001};
        vecs[4] = '{16'h0001, 1'b1, 16'h8000};
        vecs[5] = '{16'h1234, 1'b1, 16'h2C48};

        // reset
        ser_ready = 1'b1;
        #12;
        chk_reset_outs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk_reset_outs("reset_release");
        next_cyc();

        // vector table, ser_ready held high
        foreach (vecs[v]) begin
            load_word(vecs[v].data, vecs[v].dir);
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                chk($sformatf("vec%0d.valid%0d", v, i), 64'(ser_valid), 64'd1);
                chk($sformatf("vec%0d.bit%0d", v, i), 64'(ser_data),
                    64'(vecs[v].seq[i]));
                chk($sformatf("vec%0d.last%0d", v, i), 64'(ser_last),
                    64'(i == W - 1));
                chk($sformatf("vec%0d.ldrdy%0d", v, i), 64'(load_ready),
                    64'(i == W - 1));
                next_cyc();
            end
            @(negedge clk);
            chk($sformatf("vec%0d.idle", v), 64'(busy), 64'd0);
            next_cyc();
        end

        // backpressure after the fourth bit
        begin
            int xfers;
            xfers = 0;
            load_word(16'hA5C3, 1'b0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("bp.pre", 64'(ser_data), 64'(exp_bit(16'hA5C3, 1'b0, i)));
                xfers++;
                next_cyc();
            end
            ser_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("bp.hold_bit", 64'(ser_data),
                    64'(exp_bit(16'hA5C3, 1'b0, 4)));
                chk("bp.hold_last", 64'(ser_last), 64'd0);
                chk("bp.hold_valid", 64'(ser_valid), 64'd1);
                next_cyc();
            end
            ser_ready = 1'b1;
            for (int i = 4; i < W; i++) begin
                @(negedge clk);
                chk("bp.post", 64'(ser_data), 64'(exp_bit(16'hA5C3, 1'b0, i)));
                chk("bp.post_last", 64'(ser_last), 64'(i == W - 1));
                if (ser_valid) xfers++;
                next_cyc();
            end
            @(negedge clk);
            chk("bp.count", 64'(xfers), 64'(W));
            chk("bp.idle", 64'(ser_valid), 64'd0);
            next_cyc();
        end

        // clr after bit 7, then a fresh word
        load_word(16'hFFFF, 1'b1);
        for (int i = 0; i < 7; i++) next_cyc();
        clr = 1'b1;
        next_cyc();
        clr = 1'b0;
        @(negedge clk);
        chk_reset_outs("clr_mid");
        next_cyc();
        load_word(16'h0001, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("clr.after_bit", 64'(ser_data), 64'(i == 0));
            next_cyc();
        end

        // clr blocks a load offered in IDLE
        clr = 1'b1;
        load_valid = 1'b1;
        load_data = 16'hFFFF;
        next_cyc();
        clr = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        chk("clr.blocks_load", 64'(busy), 64'd0);
        next_cyc();

        // back-to-back reload with no bubble
        load_word(16'h0000, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                load_valid = 1'b1;
                load_data = 16'hFFFF;
                load_dir = 1'b0;
            end
            @(negedge clk);
            chk("b2b.first_word", 64'(ser_data), 64'd0);
            next_cyc();
            load_valid = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("b2b.no_bubble", 64'(ser_valid), 64'd1);
            chk("b2b.second_word", 64'(ser_data), 64'd1);
            next_cyc();
        end

        // async reset mid-word
        load_word(16'hFFFF, 1'b0);
        next_cyc();
        next_cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
        @(negedge clk);
        chk_reset_outs("async_rst_after");
        next_cyc();

        // randomized traffic against a bit-queue model
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = $urandom;
            load_dir   = $urandom;
            ser_ready  = ($urandom_range(0, 3) != 0);
            clr        = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            exp_rdy = (mq.size() == 0) || (mq.size() == 1 && ser_ready);
            chk("rnd.valid", 64'(ser_valid), 64'(mq.size() != 0));
            chk("rnd.busy", 64'(busy), 64'(mq.size() != 0));
            chk("rnd.load_ready", 64'(load_ready), 64'(exp_rdy));
            if (mq.size() != 0) begin
                chk("rnd.data", 64'(ser_data), 64'(mq[0]));
                chk("rnd.last", 64'(ser_last), 64'(mq.size() == 1));
            end else begin
                chk("rnd.data_idle", 64'(ser_data), 64'd0);
                chk("rnd.last_idle", 64'(ser_last), 64'd0);
            end
            if (clr) begin
                mq.delete();
            end else begin
                if (ser_ready && mq.size() != 0) void'(mq.pop_front());
                if (load_valid && exp_rdy) begin
                    for (int i = 0; i < W; i++)
                        mq.push_back(exp_bit(load_data, load_dir, i));
                end
            end
            next_cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
